md_arb: RTL

MD_ARB -- requirements
Module: md_arb

---
 rtl/md_arb_if.sv | 39 +++
 rtl/md_arb.sv | 120 ++++++++++++
 2 files changed

// File: rtl/md_arb_if.sv
// Bundle of requester handshakes, md unit drive/status and completion signals.
// master = requesters plus md unit side; slave = the md_arb arbiter.
interface md_arb_if;
    logic        req0_valid;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;
    logic [3:0]  md_op;
    logic [31:0] md_dh;
    logic [31:0] md_dl;
    logic        md_busy;
    logic        md_invalid;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        owner;
    logic        owner_valid;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output md_busy, md_invalid,
        input  req0_ready, req1_ready, md_op, md_dh, md_dl,
        input  done, err, owner, owner_valid
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  md_busy, md_invalid,
        output req0_ready, req1_ready, md_op, md_dh, md_dl,
        output done, err, owner, owner_valid
    );
endinterface

// File: rtl/md_arb.sv
// Two-requester arbiter for a shared mult/div unit; one op in flight, result owner tracked.
// MD_ARB_RR_EN selects round-robin tie-break; otherwise req0 has fixed priority.
module md_arb (
    input  logic      clk,
    input  logic      rst,
    md_arb_if.slave   bus
);
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MTHI  = 4'd1;
    localparam logic [3:0] MD_MTLO  = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd6;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        id_q;
    logic        err_q;
    logic        owner_valid_q;

    logic        eff0, eff1, gnt0, gnt1, accept, is_mt;

    // Undefined op codes behave exactly like MD_NONE: not a request.
    assign eff0  = bus.req0_valid && (bus.req0_op >= MD_MTHI) && (bus.req0_op <= MD_DIVU);
    assign eff1  = bus.req1_valid && (bus.req1_op >= MD_MTHI) && (bus.req1_op <= MD_DIVU);
    assign is_mt = (op_q == MD_MTHI) || (op_q == MD_MTLO);

`ifdef MD_ARB_RR_EN
    logic last_q;   // requester granted most recently

    assign gnt1 = eff1 && (!eff0 || !last_q);

    always_ff @(posedge clk) begin
        if (rst)
            last_q <= 1'b1;
        else if (accept)
            last_q <= gnt1;
    end
`else
    assign gnt1 = eff1 && !eff0;
`endif
    assign gnt0   = eff0 && !gnt1;
    assign accept = (state == S_IDLE) && !rst && (eff0 || eff1);

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= MD_NONE;
            a_q           <= '0;
            b_q           <= '0;
            id_q          <= 1'b0;
            err_q         <= 1'b0;
            owner_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q          <= gnt1 ? bus.req1_op : bus.req0_op;
                a_q           <= gnt1 ? bus.req1_a  : bus.req0_a;
                b_q           <= gnt1 ? bus.req1_b  : bus.req0_b;
                id_q          <= gnt1;
                err_q         <= 1'b0;
                owner_valid_q <= 1'b0;
            end
            if (state == S_GUARD)
                err_q <= bus.md_invalid;
            if (state == S_DONE)
                owner_valid_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.req0_ready  = 1'b0;
        bus.req1_ready  = 1'b0;
        bus.md_op       = MD_NONE;
        bus.md_dh       = '0;
        bus.md_dl       = '0;
        bus.done        = 2'b00;
        bus.err         = 2'b00;
        bus.owner       = id_q;
        bus.owner_valid = owner_valid_q;

        case (state)
            S_IDLE: begin
                bus.req0_ready = accept && gnt0;
                bus.req1_ready = accept && gnt1;
                if (accept)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (!rst) begin
                    bus.md_op = op_q;
                    bus.md_dh = a_q;
                    bus.md_dl = b_q;
                end
                state_nxt = is_mt ? S_DONE : S_GUARD;
            end
            // Unit has not raised busy yet; only its invalid flag is meaningful here.
            S_GUARD: state_nxt = S_WAIT;
            S_WAIT: begin
                if (!bus.md_busy)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                if (!rst) begin
                    bus.done[id_q] = 1'b1;
                    bus.err[id_q]  = err_q;
                end
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule
